// File: rtl/gauss_poly_collect_if.sv
// Sample handshake between the mkgauss sampler and its consumer.
// The consumer is the master: it raises ena, and the sampler answers with val_valid/val.
interface gauss_poly_collect_if #(
  parameter int VAL_W = 32
);
  logic             ena;
  logic             val_valid;
  logic [VAL_W-1:0] val;

  modport master (output ena, input val_valid, input val);
  modport slave  (input ena, output val_valid, output val);
endinterface

// File: rtl/gauss_poly_collect.sv
// Collects N = 2^LOGN Gaussian samples into a coefficient buffer and accumulates a
// saturating squared norm. The buffer is exposed through a registered read port.
module gauss_poly_collect #(
  parameter int LOGN   = 9,
  parameter int VAL_W  = 32,
  parameter int COEF_W = 8,
  parameter int NORM_W = 32
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  gauss_poly_collect_if.master gs,
  output logic                busy,
  output logic                done,
  output logic                ovf,
  output logic [NORM_W-1:0]   norm_sq,
  input  logic                rd_en,
  input  logic [LOGN-1:0]     rd_addr,
  output logic [COEF_W-1:0]   rd_data
);
  localparam int N  = 1 << LOGN;
  // One bit wider than both operands so the saturating add can never wrap.
  localparam int SW = ((NORM_W > 2*VAL_W) ? NORM_W : 2*VAL_W) + 1;
  localparam logic [SW-1:0] NMAX = {{(SW-NORM_W){1'b0}}, {NORM_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, REQ, GAP, FIN} state_t;

  state_t              state;
  logic [LOGN-1:0]     cnt;
  logic [COEF_W-1:0]   mem [N];
  logic                wr;
  logic [2*VAL_W-1:0]  sq;
  logic [SW-1:0]       sum;
  logic                oor;

  always_comb begin
    wr  = !rst && (state == REQ) && gs.val_valid;
    sq  = $signed(gs.val) * $signed(gs.val);
    sum = SW'(norm_sq) + SW'(sq);
    // In range iff every bit above the stored sign bit matches it.
    oor = (gs.val[VAL_W-1:COEF_W-1] != {(VAL_W-COEF_W+1){gs.val[VAL_W-1]}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gs.ena  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      norm_sq <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state   <= REQ;
          gs.ena  <= 1'b1;
          busy    <= 1'b1;
          cnt     <= '0;
          norm_sq <= '0;
          ovf     <= 1'b0;
        end
        REQ: if (gs.val_valid) begin
          gs.ena  <= 1'b0;
          norm_sq <= (sum > NMAX) ? {NORM_W{1'b1}} : sum[NORM_W-1:0];
          ovf     <= ovf | oor;
          if (cnt == {LOGN{1'b1}}) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= GAP;
          end
        end
        GAP: begin
          state  <= REQ;
          gs.ena <= 1'b1;
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Buffer survives reset; the read register samples before the write lands.
  always_ff @(posedge clk) begin
    if (wr) mem[cnt] <= gs.val[COEF_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: tb/tb_gauss_poly_collect.sv
// Directed bench for gauss_poly_collect with N=4 and a 16-bit norm accumulator.
module tb_gauss_poly_collect;
  localparam int LOGN = 2, VAL_W = 32, COEF_W = 8, NORM_W = 16;

  logic              clk = 1'b0;
  logic              rst, start, busy, done, ovf, rd_en;
  logic [NORM_W-1:0] norm_sq;
  logic [LOGN-1:0]   rd_addr;
  logic [COEF_W-1:0] rd_data;
  int                n_chk = 0, n_fail = 0;

  gauss_poly_collect_if #(.VAL_W(VAL_W)) gif ();

  gauss_poly_collect #(.LOGN(LOGN), .VAL_W(VAL_W), .COEF_W(COEF_W), .NORM_W(NORM_W)) dut (
    .clk(clk), .rst(rst), .start(start), .gs(gif.master),
    .busy(busy), .done(done), .ovf(ovf), .norm_sq(norm_sq),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for ena, present one sample, and check ena drops right after.
  task automatic send(input int v);
    int n = 0;
    while (!gif.ena && n < 10) begin
      tick();
      n++;
    end
    chk("ena_wait", {63'd0, gif.ena}, 64'd1);
    gif.val_valid = 1'b1;
    gif.val       = v;
    tick();
    gif.val_valid = 1'b0;
    chk("ena_low_after", {63'd0, gif.ena}, 64'd0);
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ena_after_start", {63'd0, gif.ena}, 64'd1);
    chk("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  task automatic rd(input int a, input logic [7:0] exp, input string tag);
    rd_en   = 1'b1;
    rd_addr = a[LOGN-1:0];
    tick();
    rd_en   = 1'b0;
    chk(tag, {56'd0, rd_data}, {56'd0, exp});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rd_en = 1'b0; rd_addr = '0;
    gif.val_valid = 1'b1; gif.val = 32'd5;
    #1;
    tick(); tick();
    chk("rst_ena", {63'd0, gif.ena}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    chk("rst_norm", {48'd0, norm_sq}, 64'd0);
    chk("rst_rd_data", {56'd0, rd_data}, 64'd0);
    rst = 1'b0; gif.val_valid = 1'b0;
    tick();

    // Basic run, with a stray sample injected during GAP.
    kick();
    send(3);
    gif.val_valid = 1'b1; gif.val = 100;
    tick();
    gif.val_valid = 1'b0;
    chk("ena_back_high", {63'd0, gif.ena}, 64'd1);
    chk("norm_gap_ignored", {48'd0, norm_sq}, 64'd9);
    send(-2); send(0); send(5);
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("norm_38", {48'd0, norm_sq}, 64'd38);
    chk("ovf_clear", {63'd0, ovf}, 64'd0);
    tick();
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("busy_drop", {63'd0, busy}, 64'd0);
    gif.val_valid = 1'b1; gif.val = 50;
    tick();
    gif.val_valid = 1'b0;
    tick();
    chk("norm_idle_ignored", {48'd0, norm_sq}, 64'd38);
    chk("ena_idle", {63'd0, gif.ena}, 64'd0);
    rd(0, 8'h03, "rd0");
    rd(1, 8'hFE, "rd1");
    rd(2, 8'h00, "rd2");
    rd(3, 8'h05, "rd3");
    rd_addr = 2'd0;
    tick();
    chk("rd_hold", {56'd0, rd_data}, 64'd5);

    // Range flag: stored values are plain truncations.
    kick();
    send(128);
    chk("ovf_first", {63'd0, ovf}, 64'd1);
    send(-129); send(1); send(1);
    chk("ovf_sticky", {63'd0, ovf}, 64'd1);
    chk("norm_range", {48'd0, norm_sq}, 64'd33027);
    tick();
    rd(0, 8'h80, "rd_128");
    rd(1, 8'h7F, "rd_m129");

    // Saturation of the 16-bit norm.
    kick();
    chk("ovf_cleared_on_start", {63'd0, ovf}, 64'd0);
    send(200); send(200);
    chk("norm_sat", {48'd0, norm_sq}, 64'd65535);
    send(1); send(1);
    chk("norm_sat_hold", {48'd0, norm_sq}, 64'd65535);
    chk("done_sat", {63'd0, done}, 64'd1);
    tick();

    // Abort mid-run, then a clean run.
    kick();
    send(3); send(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_norm", {48'd0, norm_sq}, 64'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        if (done) seen++;
        tick();
      end
      chk("abort_no_done", 64'(seen), 64'd0);
    end
    kick();
    chk("restart_norm", {48'd0, norm_sq}, 64'd0);
    send(1); send(2); send(3); send(4);
    chk("restart_done", {63'd0, done}, 64'd1);
    chk("restart_norm_30", {48'd0, norm_sq}, 64'd30);
    tick();
    rd(3, 8'h04, "restart_rd3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
